// File: rtl/resta_pf_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (a - b) with 1 bit/cycle align/normalise.
// Define RESTA_PF_RNE_EN for guard/round/sticky tracking and round-to-nearest-even.
module resta_pf_seq #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 busy
);

  localparam int unsigned MW  = MAN_W + 1;
`ifdef RESTA_PF_RNE_EN
  localparam int unsigned XB  = 3;
`else
  localparam int unsigned XB  = 0;
`endif
  localparam int unsigned W   = MW + XB;
  localparam int unsigned DW  = $clog2(MAN_W + 4);
  localparam int unsigned TOP = EXP_W + MAN_W;
  localparam logic [EXP_W:0]   ExpMax = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W-1:0] FarD   = EXP_W'(MAN_W + 4);

  typedef enum logic [2:0] {
    StIdle, StUnpack, StAlign, StSub, StNorm, StRound, StDone
  } state_e;

`ifdef RESTA_PF_RNE_EN
  localparam state_e StAfterNorm = StRound;
`else
  localparam state_e StAfterNorm = StDone;
`endif

  state_e state_q, state_d;

  logic [TOP:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic           sign_x_q, sign_x_d, sign_y_q, sign_y_d;
  logic [EXP_W:0] exp_q, exp_d;
  logic [W-1:0]   man_x_q, man_x_d, man_y_q, man_y_d;
  logic [W:0]     sum_q, sum_d;
  logic [DW-1:0]  d_q, d_d;

  // Operand unpack and magnitude ordering
  logic [EXP_W-1:0] a_e, b_e, x_e, y_e, diff;
  logic [MW-1:0]    a_m, b_m, x_m, y_m;
  logic             a_s, b_s, x_s, y_s, swap, far;

  always_comb begin
    a_e  = a_q[TOP-1:MAN_W];
    b_e  = b_q[TOP-1:MAN_W];
    a_m  = (a_e == '0) ? '0 : {1'b1, a_q[MAN_W-1:0]};
    b_m  = (b_e == '0) ? '0 : {1'b1, b_q[MAN_W-1:0]};
    a_s  = a_q[TOP];
    b_s  = ~b_q[TOP];
    swap = {b_e, b_m} > {a_e, a_m};
    {x_s, x_e, x_m} = swap ? {b_s, b_e, b_m} : {a_s, a_e, a_m};
    {y_s, y_e, y_m} = swap ? {a_s, a_e, a_m} : {b_s, b_e, b_m};
    diff = x_e - y_e;
    far  = diff >= FarD;
  end

  // Shifters; with rounding enabled bit 0 is a sticky bit that absorbs anything shifted past it
  logic [W-1:0] y_far, y_shift;
  logic [W:0]   carry_shift;
  logic         round_up;

  always_comb begin
`ifdef RESTA_PF_RNE_EN
    y_far       = W'(|y_m);
    y_shift     = {1'b0, man_y_q[W-1:2], |man_y_q[1:0]};
    carry_shift = {1'b0, sum_q[W:2], |sum_q[1:0]};
    round_up    = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
`else
    y_far       = '0;
    y_shift     = man_y_q >> 1;
    carry_shift = sum_q >> 1;
    round_up    = 1'b0;
`endif
  end

  logic [EXP_W:0] exp_inc, norm_exp, rnd_exp;
  logic [W:0]     norm_man;
  logic [MW:0]    rnd_man;
  logic           sum_zero, ovf, rnd_ovf;
  logic [TOP:0]   norm_pack, rnd_pack, inf_word, zero_word;

  always_comb begin
    exp_inc   = exp_q + (EXP_W + 1)'(1);
    ovf       = exp_inc >= ExpMax;
    sum_zero  = sum_q == '0;
    norm_man  = sum_q[W] ? carry_shift : sum_q;
    norm_exp  = sum_q[W] ? exp_inc : exp_q;
    norm_pack = {sign_x_q, norm_exp[EXP_W-1:0], norm_man[W-2:XB]};
    rnd_man   = {1'b0, sum_q[W-1:XB]} + (MW + 1)'(round_up);
    rnd_exp   = exp_q + {{EXP_W{1'b0}}, rnd_man[MW]};
    rnd_ovf   = rnd_exp >= ExpMax;
    inf_word  = {sign_x_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    zero_word = {sign_x_q, {TOP{1'b0}}};
    rnd_pack  = rnd_ovf ? inf_word : {sign_x_q, rnd_exp[EXP_W-1:0], rnd_man[MAN_W-1:0]};
  end

  logic unused_bits;
`ifdef RESTA_PF_RNE_EN
  assign unused_bits = ^{norm_man[W:W-1], norm_man[XB-1:0], rnd_man[MAN_W]};
`else
  assign unused_bits = ^{norm_man[W:W-1], rnd_man[MAN_W]};
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_valid) state_d = StUnpack;
      StUnpack: state_d = (far || diff == '0) ? StSub : StAlign;
      StAlign:  if (d_q == DW'(1)) state_d = StSub;
      StSub:    state_d = StNorm;
      StNorm: begin
        if (sum_zero)              state_d = StDone;
        else if (sum_q[W])         state_d = ovf ? StDone : StAfterNorm;
        else if (sum_q[W-1])       state_d = StAfterNorm;
        else if (exp_q <= (EXP_W + 1)'(1)) state_d = StDone;
      end
      StRound:  state_d = StDone;
      StDone:   if (out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = state_q == StIdle;
    busy      = state_q != StIdle;
    out_valid = state_q == StDone;
    result    = result_q;
  end

  // Datapath next state
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sign_x_d = sign_x_q;
    sign_y_d = sign_y_q;
    exp_d    = exp_q;
    man_x_d  = man_x_q;
    man_y_d  = man_y_q;
    sum_d    = sum_q;
    d_d      = d_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: if (in_valid) begin
        a_d = a;
        b_d = b;
      end
      StUnpack: begin
        sign_x_d = x_s;
        sign_y_d = y_s;
        exp_d    = {1'b0, x_e};
        man_x_d  = W'(x_m) << XB;
        man_y_d  = far ? y_far : (W'(y_m) << XB);
        d_d      = far ? '0 : diff[DW-1:0];
      end
      StAlign: begin
        man_y_d = y_shift;
        d_d     = d_q - DW'(1);
      end
      StSub: begin
        sum_d = (sign_x_q == sign_y_q) ? {1'b0, man_x_q} + {1'b0, man_y_q}
                                       : {1'b0, man_x_q} - {1'b0, man_y_q};
      end
      StNorm: begin
        if (sum_zero) begin
          result_d = '0;
        end else if (sum_q[W]) begin
          sum_d    = carry_shift;
          exp_d    = exp_inc;
          result_d = ovf ? inf_word : norm_pack;
        end else if (sum_q[W-1]) begin
          result_d = norm_pack;
        end else if (exp_q <= (EXP_W + 1)'(1)) begin
          result_d = zero_word;
        end else begin
          sum_d = sum_q << 1;
          exp_d = exp_q - (EXP_W + 1)'(1);
        end
      end
      StRound:  result_d = rnd_pack;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sign_x_q <= 1'b0;
      sign_y_q <= 1'b0;
      exp_q    <= '0;
      man_x_q  <= '0;
      man_y_q  <= '0;
      sum_q    <= '0;
      d_q      <= '0;
      result_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sign_x_q <= sign_x_d;
      sign_y_q <= sign_y_d;
      exp_q    <= exp_d;
      man_x_q  <= man_x_d;
      man_y_q  <= man_y_d;
      sum_q    <= sum_d;
      d_q      <= d_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_resta_pf_seq.sv
// Self-checking bench for resta_pf_seq: directed vectors, random operands against an
// arithmetic reference model, back-pressure, busy-ignore and mid-operation reset.
module tb_resta_pf_seq;

`ifdef RESTA_PF_RNE_EN
  localparam int Ext = 3;
`else
  localparam int Ext = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic [31:0] a, b, result;
  logic        in_ready, out_valid, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  resta_pf_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  // Reference: exact integer mantissa arithmetic, truncating (or sticky + RNE) alignment
  function automatic logic [31:0] model_sub(input logic [31:0] fa, input logic [31:0] fb);
    int          ea, eb, ex, ey, d, e, w;
    logic [63:0] ma, mb, mx, my, yv, s, m, lost;
    logic        sa, sb, sx, sy, g, r, st;
    ea = int'(fa[30:23]);
    eb = int'(fb[30:23]);
    ma = (ea == 0) ? 64'd0 : ({41'd0, fa[22:0]} | 64'h80_0000);
    mb = (eb == 0) ? 64'd0 : ({41'd0, fb[22:0]} | 64'h80_0000);
    sa = fa[31];
    sb = ~fb[31];
    if (eb > ea || (eb == ea && mb > ma)) begin
      ex = eb; mx = mb; sx = sb; ey = ea; my = ma; sy = sa;
    end else begin
      ex = ea; mx = ma; sx = sa; ey = eb; my = mb; sy = sb;
    end
    d  = ex - ey;
    mx = mx << Ext;
    if (d >= 27) begin
      yv = (Ext != 0 && my != 0) ? 64'd1 : 64'd0;
    end else begin
      yv   = (my << Ext) >> d;
      lost = (my << Ext) & ((64'd1 << d) - 64'd1);
      if (Ext != 0 && lost != 0) yv = yv | 64'd1;
    end
    s = (sx == sy) ? mx + yv : mx - yv;
    if (s == 0) return 32'd0;
    e = ex;
    w = 24 + Ext;
    if (s >= (64'd1 << w)) begin
      s = (Ext != 0) ? ((s >> 1) | (s & 64'd1)) : (s >> 1);
      e++;
      if (e >= 255) return {sx, 8'hFF, 23'd0};
    end else begin
      while (s < (64'd1 << (w - 1))) begin
        if (e <= 1) return {sx, 31'd0};
        s = s << 1;
        e--;
      end
    end
    m = s >> Ext;
    if (Ext != 0) begin
      g = s[2]; r = s[1]; st = s[0];
      if (g && (r || st || m[0])) m = m + 64'd1;
      if (m >= (64'd1 << 24)) begin
        m = m >> 1;
        e++;
        if (e >= 255) return {sx, 8'hFF, 23'd0};
      end
    end
    return {sx, e[7:0], m[22:0]};
  endfunction

  // One full transaction; timed_out set if either handshake never completes
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        output logic [31:0] res, output bit timed_out);
    int n;
    timed_out = 1'b0;
    res = '0;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin timed_out = 1'b1; return; end
    a = ia; b = ib; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    if (!out_valid) begin timed_out = 1'b1; return; end
    res = result;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #10;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", result); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
  endtask

  task automatic test_directed;
    logic [31:0] va [5] = '{32'h4040_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h7F7F_FFFF};
    logic [31:0] vb [5] = '{32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h3080_0000, 32'hFF7F_FFFF};
    logic [31:0] ve [5] = '{32'h4000_0000, 32'h0000_0000, 32'h4000_0000, 32'h3F80_0000, 32'h7F80_0000};
    logic [31:0] res;
    bit          to;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], res, to);
      checks++;
      if (to || res !== ve[i]) begin
        errors++;
        $display("FAIL directed_%0d a=%h b=%h got %h want %h timeout=%0d", i, va[i], vb[i], res, ve[i], to);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] ra, rb, res, want;
    bit          to;
    int          ea, eb, delta;
    for (int i = 0; i < 150; i++) begin
      ea    = int'($urandom_range(254, 1));
      delta = int'($urandom_range(60)) - 30;
      eb    = ea + delta;
      if (eb < 1) eb = 1;
      if (eb > 254) eb = 254;
      ra = {1'($urandom), 8'(ea), 23'($urandom)};
      rb = {1'($urandom), 8'(eb), 23'($urandom)};
      case ($urandom_range(9))
        0: ra[30:23] = 8'd0;
        1: rb[30:23] = 8'd0;
        2: rb = ra;
        3: rb = {~ra[31], ra[30:0]};
        4: rb = {ra[31:8], 8'($urandom)};
        default: ;
      endcase
      want = model_sub(ra, rb);
      run_op(ra, rb, res, to);
      checks++;
      if (to || res !== want) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h got %h want %h timeout=%0d", i, ra, rb, res, want, to);
      end
    end
  endtask

  task automatic test_backpressure;
    int n;
    @(negedge clk);
    a = 32'h4040_0000; b = 32'h3F80_0000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== 32'h4000_0000 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d got out_valid=%b result=%h in_ready=%b want 1/40000000/0",
                 i, out_valid, result, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_idle got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_busy_ignore;
    int n;
    int extra;
    @(negedge clk);
    a = 32'h4040_0000; b = 32'h3F80_0000; in_valid = 1'b1;
    @(negedge clk);
    a = 32'h7F7F_FFFF; b = 32'hFF7F_FFFF;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL busy_%0d got in_ready=%b busy=%b want 0/1", i, in_ready, busy);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h4000_0000) begin
      errors++; $display("FAIL busy_result got valid=%b result=%h want 1/40000000", out_valid, result);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL busy_no_second got %0d valid cycles want 0", extra); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] res;
    bit          to;
    int          seen;
    @(negedge clk);
    a = 32'h3F80_0000; b = 32'h3880_0000; in_valid = 1'b1;  // d = 14 alignment steps
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_reset got out_valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_after_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid || busy) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_result got %0d active cycles want 0", seen); end
    run_op(32'h4040_0000, 32'h3F80_0000, res, to);
    checks++;
    if (to || res !== 32'h4000_0000) begin
      errors++; $display("FAIL abort_recover got %h want 40000000 timeout=%0d", res, to);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #2 rst_n  = 1'b0;
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_busy_ignore;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
